// File: rtl/list_walker.sv
// list_walker
//   Traversal controller for a linked list held in a combinational ROM. A start
//   pulse launches a walk from a head address. Each node is fetched and its
//   payload is offered on a valid/ready stream. The walk ends on the null
//   pointer (done pulse), on the hop limit (loop_err pulse), or on abort (no pulse).
//
//   Node word layout: {next[ADDR_W-1:0], payload[WIDTH-ADDR_W-1:0]}
//
// Ports
//   i_clk          rising-edge clock
//   i_rst_n        asynchronous active-low reset
//   i_start        begin a walk; sampled only while idle
//   i_head         first node address, sampled with i_start
//   i_abort        synchronous cancel, effective in any state
//   o_rom_addr     registered ROM address
//   i_rom_data     ROM word for o_rom_addr, same cycle
//   o_item_valid   payload available
//   i_item_ready   consumer accepts payload
//   o_item_data    node payload
//   o_item_index   0-based position of the item within the walk
//   o_busy         walk in progress
//   o_done         1-cycle pulse: list ended at the null pointer
//   o_loop_err     1-cycle pulse: hop limit reached without the null pointer

module list_walker #(
  parameter int unsigned       WIDTH    = 8,
  parameter int unsigned       ADDR_W   = 4,
  parameter logic [ADDR_W-1:0] NULL_PTR = 4'hF,
  parameter int unsigned       MAX_HOPS = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic [ADDR_W-1:0]       i_head,
  input  logic                    i_abort,
  output logic [ADDR_W-1:0]       o_rom_addr,
  input  logic [WIDTH-1:0]        i_rom_data,
  output logic                    o_item_valid,
  input  logic                    i_item_ready,
  output logic [WIDTH-ADDR_W-1:0] o_item_data,
  output logic [ADDR_W-1:0]       o_item_index,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_loop_err
);

  localparam int unsigned       PayW    = WIDTH - ADDR_W;
  // Index of the last item a walk may emit before the loop guard trips.
  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(MAX_HOPS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StEmit
  } state_e;

  state_e            r_state;
  logic [ADDR_W-1:0] r_rom_addr;
  logic [ADDR_W-1:0] r_next_ptr;
  logic              r_item_valid;
  logic [PayW-1:0]   r_item_data;
  logic [ADDR_W-1:0] r_item_index;
  logic              r_done;
  logic              r_loop_err;

  state_e            w_state;
  logic [ADDR_W-1:0] w_rom_addr;
  logic [ADDR_W-1:0] w_next_ptr;
  logic              w_item_valid;
  logic [PayW-1:0]   w_item_data;
  logic [ADDR_W-1:0] w_item_index;
  logic              w_done;
  logic              w_loop_err;
  logic              w_handshake;

  assign w_handshake = r_item_valid & i_item_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_rom_addr   <= '0;
      r_next_ptr   <= '0;
      r_item_valid <= 1'b0;
      r_item_data  <= '0;
      r_item_index <= '0;
      r_done       <= 1'b0;
      r_loop_err   <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_rom_addr   <= w_rom_addr;
      r_next_ptr   <= w_next_ptr;
      r_item_valid <= w_item_valid;
      r_item_data  <= w_item_data;
      r_item_index <= w_item_index;
      r_done       <= w_done;
      r_loop_err   <= w_loop_err;
    end
  end

  always_comb begin
    w_state      = r_state;
    w_rom_addr   = r_rom_addr;
    w_next_ptr   = r_next_ptr;
    w_item_valid = r_item_valid;
    w_item_data  = r_item_data;
    w_item_index = r_item_index;
    w_done       = 1'b0;
    w_loop_err   = 1'b0;

    if (i_abort) begin
      // Abort overrides everything, including a start in idle and a
      // coincident handshake; no completion pulse is raised.
      w_state      = StIdle;
      w_item_valid = 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            if (i_head == NULL_PTR) begin
              // Empty list: report completion without emitting anything.
              w_done = 1'b1;
            end else begin
              w_rom_addr   = i_head;
              w_item_index = '0;
              w_state      = StFetch;
            end
          end
        end

        StFetch: begin
          w_item_data  = i_rom_data[PayW-1:0];
          w_next_ptr   = i_rom_data[WIDTH-1 -: ADDR_W];
          w_item_valid = 1'b1;
          w_state      = StEmit;
        end

        StEmit: begin
          if (w_handshake) begin
            w_item_valid = 1'b0;
            if (r_next_ptr == NULL_PTR) begin
              w_done  = 1'b1;
              w_state = StIdle;
            end else if (r_item_index == LastIdx) begin
              // Hop guard: catches self-loops and longer cycles.
              w_loop_err = 1'b1;
              w_state    = StIdle;
            end else begin
              w_rom_addr   = r_next_ptr;
              w_item_index = r_item_index + 1'b1;
              w_state      = StFetch;
            end
          end
        end

        default: begin
          w_state      = StIdle;
          w_item_valid = 1'b0;
        end
      endcase
    end
  end

  assign o_rom_addr   = r_rom_addr;
  assign o_item_valid = r_item_valid;
  assign o_item_data  = r_item_data;
  assign o_item_index = r_item_index;
  assign o_busy       = (r_state != StIdle);
  assign o_done       = r_done;
  assign o_loop_err   = r_loop_err;

endmodule

// File: tb/tb_list_walker.sv
module tb_list_walker;

  localparam int         MaxH  = 16;
  localparam logic [3:0] NullP = 4'hF;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b0;
  logic       start      = 1'b0;
  logic       abort      = 1'b0;
  logic       item_ready = 1'b0;
  logic [3:0] head       = 4'h0;

  logic [3:0] rom_addr;
  logic [7:0] rom_data;
  logic       item_valid;
  logic [3:0] item_data;
  logic [3:0] item_index;
  logic       busy;
  logic       done;
  logic       loop_err;

  logic [7:0] rom [16];

  int n_checks = 0;
  int n_fail   = 0;
  int g;

  assign rom_data = rom[rom_addr];

  always #5 clk = ~clk;

  list_walker #(
    .WIDTH   (8),
    .ADDR_W  (4),
    .NULL_PTR(4'hF),
    .MAX_HOPS(16)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_head      (head),
    .i_abort     (abort),
    .o_rom_addr  (rom_addr),
    .i_rom_data  (rom_data),
    .o_item_valid(item_valid),
    .i_item_ready(item_ready),
    .o_item_data (item_data),
    .o_item_index(item_index),
    .o_busy      (busy),
    .o_done      (done),
    .o_loop_err  (loop_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One complete walk from h. Expected items come from following the ROM
  // pointers directly. Ready is random with ready_pct percent, except that
  // item stall_idx is held off for stall_len cycles.
  task automatic do_walk(input logic [3:0] h, input int ready_pct, input int stall_idx,
                         input int stall_len, input bit chk_thru);
    logic [3:0] ed[$];
    logic [3:0] ea[$];
    logic [3:0] a;
    bit         exp_loop;
    int         ncyc, n_items, ndone, nloop, first_valid, last_hs, end_cyc, stall_cnt;

    exp_loop = 1'b0;
    a        = h;
    if (h != NullP) begin
      for (int k = 0; k < MaxH; k++) begin
        ed.push_back(rom[a][3:0]);
        ea.push_back(a);
        if (rom[a][7:4] == NullP) break;
        if (k == MaxH - 1) exp_loop = 1'b1;
        else a = rom[a][7:4];
      end
    end

    head        = h;
    start       = 1'b1;
    abort       = 1'b0;
    item_ready  = 1'b0;
    tick();
    start       = 1'b0;
    ncyc        = 1;
    n_items     = 0;
    ndone       = 0;
    nloop       = 0;
    first_valid = -1;
    last_hs     = -1;
    end_cyc     = -1;
    stall_cnt   = 0;

    while (ncyc < 1000) begin
      if (done || loop_err) begin
        if (end_cyc < 0) end_cyc = ncyc;
        if (done) ndone++;
        if (loop_err) nloop++;
      end
      if (item_valid && first_valid < 0) first_valid = ncyc;
      if (!busy) break;

      if (item_valid && int'(item_index) == stall_idx && stall_cnt < stall_len) begin
        item_ready = 1'b0;
        stall_cnt++;
        check("stall_data", 32'(item_data), 32'(ed[stall_idx]));
        check("stall_index", 32'(item_index), 32'(stall_idx));
      end else begin
        item_ready = ($urandom_range(0, 99) < ready_pct);
      end
      // start while busy must be ignored
      start = 1'($urandom_range(0, 1));
      head  = 4'($urandom);

      if (item_valid && item_ready) begin
        if (n_items < ed.size()) begin
          check("item_data", 32'(item_data), 32'(ed[n_items]));
          check("item_index", 32'(item_index), 32'(n_items));
          check("rom_addr", 32'(rom_addr), 32'(ea[n_items]));
        end else begin
          check("extra_item", 32'(n_items), 32'(ed.size()));
        end
        if (chk_thru && last_hs >= 0) check("throughput", 32'(ncyc - last_hs), 32'd2);
        last_hs = ncyc;
        n_items++;
      end
      tick();
      ncyc++;
    end
    start      = 1'b0;
    item_ready = 1'b0;
    check("walk_timeout", 32'(ncyc < 1000), 32'd1);

    tick();
    if (done) ndone++;
    if (loop_err) nloop++;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_valid", 32'(item_valid), 32'd0);
    check("item_count", 32'(n_items), 32'(ed.size()));
    check("done_count", 32'(ndone), 32'(!exp_loop));
    check("loop_count", 32'(nloop), 32'(exp_loop));
    if (ed.size() > 0) begin
      check("first_latency", 32'(first_valid), 32'd2);
      check("end_pulse_cyc", 32'(end_cyc), 32'(last_hs + 1));
    end else begin
      check("null_done_cyc", 32'(end_cyc), 32'd1);
      check("null_no_valid", 32'(first_valid), 32'hFFFF_FFFF);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 8'hFF;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_valid", 32'(item_valid), 32'd0);
    check("rst_data", 32'(item_data), 32'd0);
    check("rst_index", 32'(item_index), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_loop", 32'(loop_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();

    // Three-node list A,B,C
    rom[0] = 8'h3A;
    rom[3] = 8'h5B;
    rom[5] = 8'hFC;
    do_walk(4'h0, 100, -1, 0, 1'b1);

    // Consumer stalls five cycles on item B
    do_walk(4'h0, 100, 1, 5, 1'b0);

    // Two-node cycle trips the hop guard
    rom[1] = 8'h21;
    rom[2] = 8'h12;
    do_walk(4'h1, 100, -1, 0, 1'b1);

    // Null head
    do_walk(NullP, 100, -1, 0, 1'b0);

    // start and abort together in idle
    head  = 4'h0;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", 32'(busy), 32'd0);
    check("start_abort_done", 32'(done), 32'd0);
    tick();
    check("start_abort_valid", 32'(item_valid), 32'd0);

    // Abort while item B is offered
    head       = 4'h0;
    start      = 1'b1;
    item_ready = 1'b1;
    tick();
    start = 1'b0;
    g     = 0;
    while (!(item_valid && item_index == 4'd1) && g < 50) begin
      tick();
      g++;
    end
    check("abort_reach_b", 32'(g < 50), 32'd1);
    abort      = 1'b1;
    item_ready = 1'($urandom_range(0, 1));
    tick();
    abort      = 1'b0;
    item_ready = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(item_valid), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_loop", 32'(loop_err), 32'd0);
    repeat (3) begin
      tick();
      check("abort_quiet", 32'(item_valid | done | loop_err | busy), 32'd0);
    end
    do_walk(4'h0, 100, -1, 0, 1'b1);

    // Longest terminating chain: 15 distinct nodes, ends at index 14 with done
    for (int i = 0; i < 14; i++) rom[i] = {4'(i + 1), 4'(i)};
    rom[14] = 8'hFE;
    do_walk(4'h0, 100, -1, 0, 1'b1);

    // Asynchronous reset mid-walk
    rom[0]     = 8'h3A;
    rom[3]     = 8'h5B;
    rom[5]     = 8'hFC;
    head       = 4'h3;
    start      = 1'b1;
    item_ready = 1'b0;
    tick();
    start = 1'b0;
    tick();
    check("pre_reset_valid", 32'(item_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_rom_addr", 32'(rom_addr), 32'd0);
    check("arst_valid", 32'(item_valid), 32'd0);
    check("arst_data", 32'(item_data), 32'd0);
    check("arst_index", 32'(item_index), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_loop", 32'(loop_err), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    start = 1'b1;
    head  = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check("held_rst_busy", 32'(busy), 32'd0);
    check("held_rst_valid", 32'(item_valid), 32'd0);
    rst_n = 1'b1;
    start = 1'b0;
    tick();
    check("post_rst_busy", 32'(busy), 32'd0);
    do_walk(4'h0, 100, -1, 0, 1'b1);

    // Random ROM images, heads and consumer back-pressure
    for (int w = 0; w < 12; w++) begin
      for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
      do_walk(4'($urandom), int'($urandom_range(30, 100)), -1, 0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
